// File: rtl/VX_gpu_pkg.sv
// Shared definitions for the socket-level L1 memory scheduler.
//   L1_SCHED_SEL_BITS    : width of the source-select field appended to
//                          memory tags (0 when there is a single input).
//   L1_SCHED_STARVE_W    : width of a per-input starve counter.
//   L1_MEM_ARB_TAG_WIDTH : width of the memory-side tag {req_tag, sel}.
package VX_gpu_pkg;

  function automatic int L1_SCHED_SEL_BITS(input int num_inputs);
    return (num_inputs > 1) ? $clog2(num_inputs) : 0;
  endfunction

  function automatic int L1_SCHED_STARVE_W(input int max_starve);
    return $clog2(max_starve + 1);
  endfunction

  function automatic int L1_MEM_ARB_TAG_WIDTH(input int num_inputs, input int tag_width);
    return tag_width + L1_SCHED_SEL_BITS(num_inputs);
  endfunction

endpackage

// File: rtl/vx_l1_starve_arb.sv
// Fixed-priority arbiter (input 0 highest) with anti-starvation override.
// Every input i>0 counts the accepted requests it lost while it was valid
// and eligible; once a valid input reaches MAX_STARVE the arbiter enters
// STARVE mode and the lowest-index starved input beats input 0.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   valid      : per-input request valid
//   eligible   : per-input eligibility (write, or read with credit)
//   fire       : the granted request was accepted this cycle
//   grant      : one-hot grant (all zero when nothing is eligible)
module vx_l1_starve_arb
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int MAX_STARVE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [NUM_INPUTS-1:0] eligible,
  input  logic                  fire,
  output logic [NUM_INPUTS-1:0] grant
);

  localparam int               CNT_W   = L1_SCHED_STARVE_W(MAX_STARVE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STARVE);

  logic [CNT_W-1:0]      starve_cnt     [NUM_INPUTS];
  logic [CNT_W-1:0]      starve_cnt_nxt [NUM_INPUTS];
  logic                  starve_mode;
  logic                  starve_mode_nxt;
  logic [NUM_INPUTS-1:0] cand;
  logic [NUM_INPUTS-1:0] starved;
  logic [NUM_INPUTS-1:0] pick;

  always_comb begin
    cand    = valid & eligible;
    starved = '0;
    for (int i = 1; i < NUM_INPUTS; i++) begin
      starved[i] = cand[i] & (starve_cnt[i] == CNT_MAX);
    end
    // A starved input that is itself ineligible cannot be forced through;
    // normal priority then keeps the bus busy until it becomes eligible.
    pick  = (starve_mode && (starved != '0)) ? starved : cand;
    grant = pick & (~pick + NUM_INPUTS'(1));
  end

  always_comb begin
    starve_mode_nxt = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (i == 0 || !valid[i] || (fire && grant[i])) begin
        starve_cnt_nxt[i] = '0;
      end else if (fire && eligible[i] && starve_cnt[i] != CNT_MAX) begin
        starve_cnt_nxt[i] = starve_cnt[i] + CNT_W'(1);
      end else begin
        starve_cnt_nxt[i] = starve_cnt[i];
      end
      if (starve_cnt_nxt[i] == CNT_MAX) begin
        starve_mode_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_mode <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        starve_cnt[i] <= '0;
      end
    end else begin
      starve_mode <= starve_mode_nxt;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        starve_cnt[i] <= starve_cnt_nxt[i];
      end
    end
  end

endmodule

// File: rtl/vx_l1_mem_sched.sv
// Socket-level scheduler sharing one memory bus between NUM_INPUTS L1
// memory ports (0 = icache, 1 = dcache). Requests pass through a 2-entry
// elastic buffer (accepted in T, on mem_req_* in T+1, 1 req/cycle).
// Outstanding reads are capped at MAX_PENDING; responses are routed back
// combinationally by the select field held in the tag LSBs.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_*                 : per-input request channel (flattened vectors)
//   mem_req_*             : memory request channel, tag = {req_tag, sel}
//   mem_rsp_*             : memory response channel
//   rsp_valid/rsp_ready   : per-input response handshake
//   rsp_data/rsp_tag      : broadcast response data, tag with sel removed
//   busy                  : reads outstanding or requests buffered
//   perf_stall_cycles     : per-input stall counters, only when the
//                           L1_SCHED_PERF_EN macro is defined
module vx_l1_mem_sched
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_SIZE   = 64,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_STARVE  = 8,
  parameter int MAX_PENDING = 16
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_INPUTS-1:0]                                  req_valid,
  input  logic [NUM_INPUTS-1:0]                                  req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]                       req_addr,
  input  logic [NUM_INPUTS*DATA_SIZE*8-1:0]                      req_data,
  input  logic [NUM_INPUTS*DATA_SIZE-1:0]                        req_byteen,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]                        req_tag,
  output logic [NUM_INPUTS-1:0]                                  req_ready,
  output logic                                                   mem_req_valid,
  output logic                                                   mem_req_rw,
  output logic [ADDR_WIDTH-1:0]                                  mem_req_addr,
  output logic [DATA_SIZE*8-1:0]                                 mem_req_data,
  output logic [DATA_SIZE-1:0]                                   mem_req_byteen,
  output logic [L1_MEM_ARB_TAG_WIDTH(NUM_INPUTS, TAG_WIDTH)-1:0] mem_req_tag,
  input  logic                                                   mem_req_ready,
  input  logic                                                   mem_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]                                 mem_rsp_data,
  input  logic [L1_MEM_ARB_TAG_WIDTH(NUM_INPUTS, TAG_WIDTH)-1:0] mem_rsp_tag,
  output logic                                                   mem_rsp_ready,
  output logic [NUM_INPUTS-1:0]                                  rsp_valid,
  output logic [DATA_SIZE*8-1:0]                                 rsp_data,
  output logic [TAG_WIDTH-1:0]                                   rsp_tag,
  input  logic [NUM_INPUTS-1:0]                                  rsp_ready,
  output logic                                                   busy
`ifdef L1_SCHED_PERF_EN
  ,
  output logic [NUM_INPUTS*32-1:0]                               perf_stall_cycles
`endif
);

  localparam int SEL_BITS  = L1_SCHED_SEL_BITS(NUM_INPUTS);
  localparam int SEL_W     = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int MEM_TAG_W = L1_MEM_ARB_TAG_WIDTH(NUM_INPUTS, TAG_WIDTH);
  localparam int DATA_W    = DATA_SIZE * 8;
  localparam int PEND_W    = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_SIZE-1:0]  byteen;
    logic [MEM_TAG_W-1:0]  tag;
  } mem_req_t;

  logic [NUM_INPUTS-1:0] eligible;
  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_W-1:0]      grant_idx;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [MEM_TAG_W-1:0]  push_tag;
  mem_req_t              push_req;
  logic                  push;
  logic                  pop;
  logic                  credit_ok;
  logic                  rd_push;
  logic                  rsp_fire;
  logic                  rsp_dec;
  logic [PEND_W-1:0]     pending;
  logic [SEL_W-1:0]      rsp_sel;
  logic                  rsp_sel_ok;

  mem_req_t              req_buf_p1 [2];
  logic                  wr_ptr_p1;
  logic                  rd_ptr_p1;
  logic [1:0]            buf_cnt_p1;
  logic                  buf_full;
  logic                  buf_empty;

  assign credit_ok = (pending != PEND_MAX);
  assign eligible  = req_rw | {NUM_INPUTS{credit_ok}};
  assign buf_full  = (buf_cnt_p1 == 2'd2);
  assign buf_empty = (buf_cnt_p1 == 2'd0);

  vx_l1_starve_arb #(
    .NUM_INPUTS (NUM_INPUTS),
    .MAX_STARVE (MAX_STARVE)
  ) starve_arb (
    .clk      (clk),
    .reset    (reset),
    .valid    (req_valid),
    .eligible (eligible),
    .fire     (push),
    .grant    (grant)
  );

  // Nothing is accepted while reset is held, so the buffer cannot refill
  // in the same cycle it is being flushed.
  assign req_ready = reset ? '0 : (grant & {NUM_INPUTS{!buf_full}});
  assign push      = |(req_valid & req_ready);
  assign pop       = !buf_empty && mem_req_ready;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        grant_idx = SEL_W'(i);
      end
    end
  end

  assign sel_tag = req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];

  if (SEL_BITS == 0) begin : g_nosel
    assign push_tag = sel_tag;
    assign rsp_sel  = '0;
    assign rsp_tag  = mem_rsp_tag;
  end else begin : g_sel
    assign push_tag = {sel_tag, grant_idx};
    assign rsp_sel  = mem_rsp_tag[SEL_BITS-1:0];
    assign rsp_tag  = mem_rsp_tag[MEM_TAG_W-1:SEL_BITS];
  end

  always_comb begin
    push_req.rw     = req_rw[grant_idx];
    push_req.addr   = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    push_req.data   = req_data[grant_idx*DATA_W +: DATA_W];
    push_req.byteen = req_byteen[grant_idx*DATA_SIZE +: DATA_SIZE];
    push_req.tag    = push_tag;
  end

  // ---- stage p0 -> p1: accepted request enters the elastic buffer ----
  always_ff @(posedge clk) begin
    if (push) begin
      req_buf_p1[wr_ptr_p1] <= push_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_p1  <= 1'b0;
      rd_ptr_p1  <= 1'b0;
      buf_cnt_p1 <= 2'd0;
    end else begin
      if (push) wr_ptr_p1 <= !wr_ptr_p1;
      if (pop)  rd_ptr_p1 <= !rd_ptr_p1;
      case ({push, pop})
        2'b10:   buf_cnt_p1 <= buf_cnt_p1 + 2'd1;
        2'b01:   buf_cnt_p1 <= buf_cnt_p1 - 2'd1;
        default: buf_cnt_p1 <= buf_cnt_p1;
      endcase
    end
  end

  assign mem_req_valid  = !buf_empty;
  assign mem_req_rw     = req_buf_p1[rd_ptr_p1].rw;
  assign mem_req_addr   = req_buf_p1[rd_ptr_p1].addr;
  assign mem_req_data   = req_buf_p1[rd_ptr_p1].data;
  assign mem_req_byteen = req_buf_p1[rd_ptr_p1].byteen;
  assign mem_req_tag    = req_buf_p1[rd_ptr_p1].tag;

  // Read credits: writes never return a response, so only reads count.
  // A stray response at zero is tolerated (e.g. after a mid-flight reset)
  // without wrapping the counter.
  assign rd_push  = push && !push_req.rw;
  assign rsp_fire = mem_rsp_valid && mem_rsp_ready;
  assign rsp_dec  = rsp_fire && (pending != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      case ({rd_push, rsp_dec})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  assign busy = (pending != '0) || !buf_empty;

  // Response routing; an out-of-range select is drained (ready=1).
  assign rsp_sel_ok = (int'(rsp_sel) < NUM_INPUTS);
  assign rsp_data   = mem_rsp_data;

  always_comb begin
    rsp_valid     = '0;
    mem_rsp_ready = 1'b1;
    if (rsp_sel_ok) begin
      rsp_valid[rsp_sel] = mem_rsp_valid;
      mem_rsp_ready      = rsp_ready[rsp_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_fire && pending == '0))
        else $error("vx_l1_mem_sched: response with no outstanding read");
      assert (!(mem_rsp_valid && !rsp_sel_ok))
        else $error("vx_l1_mem_sched: response select out of range");
    end
  end

`ifdef L1_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          perf_stall_cycles[i*32 +: 32] <= perf_stall_cycles[i*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_l1_mem_sched.sv
module tb_vx_l1_mem_sched;

  localparam int N   = 2;
  localparam int AW  = 26;
  localparam int DS  = 64;
  localparam int TW  = 8;
  localparam int MS  = 8;
  localparam int MP  = 16;
  localparam int DW  = DS * 8;
  localparam int MTW = TW + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_rw;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*DS-1:0] req_byteen;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    req_ready;
  logic            mem_req_valid;
  logic            mem_req_rw;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [DS-1:0]   mem_req_byteen;
  logic [MTW-1:0]  mem_req_tag;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic [MTW-1:0]  mem_rsp_tag;
  logic            mem_rsp_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [TW-1:0]   rsp_tag;
  logic [N-1:0]    rsp_ready;
  logic            busy;

  vx_l1_mem_sched #(
    .NUM_INPUTS (N), .ADDR_WIDTH (AW), .DATA_SIZE (DS), .TAG_WIDTH (TW),
    .MAX_STARVE (MS), .MAX_PENDING (MP)
  ) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_rw (req_rw), .req_addr (req_addr),
    .req_data (req_data), .req_byteen (req_byteen), .req_tag (req_tag),
    .req_ready (req_ready),
    .mem_req_valid (mem_req_valid), .mem_req_rw (mem_req_rw),
    .mem_req_addr (mem_req_addr), .mem_req_data (mem_req_data),
    .mem_req_byteen (mem_req_byteen), .mem_req_tag (mem_req_tag),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid), .mem_rsp_data (mem_rsp_data),
    .mem_rsp_tag (mem_rsp_tag), .mem_rsp_ready (mem_rsp_ready),
    .rsp_valid (rsp_valid), .rsp_data (rsp_data), .rsp_tag (rsp_tag),
    .rsp_ready (rsp_ready), .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DS-1:0] be;
    logic [MTW-1:0] tag;
  } req_t;

  req_t mq[$];
  int   m_pend   = 0;
  int   m_lost   = 0;
  bit   model_on = 1'b0;

  always @(negedge clk) begin : model_cmp
    logic [N-1:0] cand;
    logic [N-1:0] exp_rdy;
    int           win;
    bit           space;
    req_t         e;
    if (model_on) begin
      for (int i = 0; i < N; i++) cand[i] = req_valid[i] & (req_rw[i] | (m_pend < MP));
      win = -1;
      if (cand[1] && m_lost >= MS) win = 1;
      else if (cand[0])            win = 0;
      else if (cand[1])            win = 1;
      space   = (mq.size() < 2);
      exp_rdy = '0;
      if (!reset && win >= 0 && space) exp_rdy[win] = 1'b1;

      check("req_ready", req_ready, exp_rdy);
      check("mem_req_valid", mem_req_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("mem_req_rw", mem_req_rw, mq[0].rw);
        check("mem_req_addr", mem_req_addr, mq[0].addr);
        check("mem_req_data", mem_req_data, mq[0].data);
        check("mem_req_byteen", mem_req_byteen, mq[0].be);
        check("mem_req_tag", mem_req_tag, mq[0].tag);
      end
      check("busy", busy, (m_pend != 0) || (mq.size() != 0));
      check("rsp_valid", rsp_valid, mem_rsp_valid ? (2'b01 << mem_rsp_tag[0]) : 2'b00);
      check("mem_rsp_ready", mem_rsp_ready, rsp_ready[mem_rsp_tag[0]]);
      check("rsp_tag", rsp_tag, mem_rsp_tag >> 1);
      check("rsp_data", rsp_data, mem_rsp_data);

      if (!reset) begin
        if (mq.size() != 0 && mem_req_ready) void'(mq.pop_front());
        if (exp_rdy != '0) begin
          e.rw   = req_rw[win];
          e.addr = req_addr[win*AW +: AW];
          e.data = req_data[win*DW +: DW];
          e.be   = req_byteen[win*DS +: DS];
          e.tag  = {req_tag[win*TW +: TW], (win == 1)};
          mq.push_back(e);
          if (!e.rw) m_pend++;
        end
        if (!req_valid[1] || exp_rdy[1]) m_lost = 0;
        else if (exp_rdy[0] && cand[1] && m_lost < MS) m_lost++;
        if (mem_rsp_valid && rsp_ready[mem_rsp_tag[0]] && m_pend > 0) m_pend--;
      end
    end
    if (reset) begin
      mq.delete();
      m_pend   = 0;
      m_lost   = 0;
      model_on = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid     = '0;
    req_rw        = '0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
    req_valid[i]            = 1'b1;
    req_rw[i]               = rw;
    req_addr[i*AW +: AW]    = a;
    req_data[i*DW +: DW]    = {16{6'(i), a}};
    req_byteen[i*DS +: DS]  = {DS{1'b1}} ^ DS'(a);
    req_tag[i*TW +: TW]     = t;
  endtask

  task automatic rsp(input logic [MTW-1:0] t);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = t;
    mem_rsp_data  = {16{23'h0, t}};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g1[$];
    reset = 1'b1; req_valid = '0; req_rw = '1; req_addr = '0; req_data = '0;
    req_byteen = '0; req_tag = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    mem_rsp_data = '0; mem_rsp_tag = '0; rsp_ready = 2'b11;
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_mem_req_valid", mem_req_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    tick(); reset = 1'b0; idle();

    // Tag/select round trip on input 1.
    tick(); set_req(1, 1'b0, 26'h123, 8'h5A);
    @(negedge clk); check("tag_accept", req_ready, 2'b10);
    tick(); idle();
    @(negedge clk); check("tag_mem_valid", mem_req_valid, 1'b1);
    check("tag_mem_tag", mem_req_tag, 9'h0B5);
    check("tag_mem_addr", mem_req_addr, 26'h123);
    tick(); rsp(9'h0B5); rsp_ready = 2'b10;
    @(negedge clk); check("tag_rsp_valid", rsp_valid, 2'b10);
    check("tag_rsp_tag", rsp_tag, 8'h5A);
    check("tag_mem_rsp_ready", mem_rsp_ready, 1'b1);
    tick(); mem_rsp_valid = 1'b0; rsp_ready = 2'b11;
    @(negedge clk); check("tag_busy_clear", busy, 1'b0);

    // Starvation: both inputs write every cycle.
    for (int k = 0; k < 18; k++) begin
      tick(); set_req(0, 1'b1, 26'h1000 + k, 8'h10 + k); set_req(1, 1'b1, 26'h2000 + k, 8'h20 + k);
      @(negedge clk); if (req_ready[1]) g1.push_back(k);
    end
    check("starve_grant_count", g1.size(), 2);
    check("starve_first_grant", (g1.size() > 0) ? g1[0] : -1, 8);
    check("starve_second_grant", (g1.size() > 1) ? g1[1] : -1, 17);
    tick(); idle();
    tick(); tick();

    // Read credits exhausted; a write still passes.
    for (int k = 0; k < 16; k++) begin
      tick(); set_req(0, 1'b0, 26'h3000 + k, 8'h30 + k);
    end
    tick(); set_req(0, 1'b0, 26'h3010, 8'h40); set_req(1, 1'b1, 26'h4000, 8'h41);
    @(negedge clk); check("credit_write_passes", req_ready, 2'b10);
    tick(); req_valid[1] = 1'b0; rsp(9'h060);
    @(negedge clk); check("credit_read_held", req_ready, 2'b00);
    check("credit_rsp_valid", rsp_valid, 2'b01);
    tick(); mem_rsp_valid = 1'b0;
    @(negedge clk); check("credit_read_resumes", req_ready, 2'b01);
    tick(); idle();
    for (int k = 0; k < 11; k++) begin
      tick(); rsp(MTW'(k * 2));
    end
    // Accept and respond in the same cycle at pending=5.
    tick(); set_req(0, 1'b0, 26'h5000, 8'h50); rsp(9'h0A0);
    @(negedge clk); check("same_cycle_accept", req_ready, 2'b01);
    tick(); idle();
    @(negedge clk); check("same_cycle_busy", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(); rsp(MTW'(k * 4));
    end
    tick(); mem_rsp_valid = 1'b0;
    @(negedge clk); check("pending_one_left", busy, 1'b1);
    tick(); rsp(9'h002);
    tick(); mem_rsp_valid = 1'b0;
    @(negedge clk); check("pending_drained", busy, 1'b0);

    // Back-pressure: buffer fills after two accepts, order preserved.
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); set_req(0, 1'b1, 26'h600 + k, 8'h60 + k); set_req(1, 1'b1, 26'h700, 8'h70);
      @(negedge clk); check("bp_ready", req_ready, (k < 2) ? 2'b01 : 2'b00);
    end
    tick(); idle(); mem_req_ready = 1'b1;
    @(negedge clk); check("bp_first_out", mem_req_addr, 26'h600);
    tick();
    @(negedge clk); check("bp_second_out", mem_req_addr, 26'h601);
    tick();
    @(negedge clk); check("bp_empty", mem_req_valid, 1'b0);

    // Reset with 3 reads pending and the buffer full.
    tick(); set_req(0, 1'b0, 26'h800, 8'h80);
    tick(); set_req(0, 1'b0, 26'h801, 8'h81);
    tick(); mem_req_ready = 1'b0; set_req(0, 1'b0, 26'h802, 8'h82);
    tick(); set_req(0, 1'b0, 26'h803, 8'h83);
    @(negedge clk); check("rst_pre_full", req_ready, 2'b00);
    check("rst_pre_busy", busy, 1'b1);
    tick(); reset = 1'b1;
    @(negedge clk); check("rst_ready_gated", req_ready, 2'b00);
    tick();
    @(negedge clk); check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    tick(); reset = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk); check("rst_resume", req_ready, 2'b01);
    tick(); idle();
    @(negedge clk); check("rst_resume_valid", mem_req_valid, 1'b1);
    check("rst_resume_addr", mem_req_addr, 26'h803);
    tick(); rsp(9'h106);
    tick(); mem_rsp_valid = 1'b0;
    @(negedge clk); check("final_idle", busy, 1'b0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
